// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if
//   Bundles every signal between the round-robin adder arbiter, its N
//   requesters and the shared registered 8-bit adder.
//   Ports (seen from the arbiter, modport slave):
//     req, lock, cin_in [N]      requester controls
//     a_in, b_in [8*N]           packed operands, requester i uses [8i+7:8i]
//     gnt [N]                    one-hot accept (combinational)
//     add_a, add_b, add_cin      operands steered to the adder
//     add_sum, add_cout          registered adder result
//     rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_chained   tagged response
//   modport master is the requester/adder side of the same bundle.
interface adder_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [8*N-1:0] a_in;
  logic [8*N-1:0] b_in;
  logic [N-1:0]   cin_in;
  logic [N-1:0]   gnt;
  logic [7:0]     add_a;
  logic [7:0]     add_b;
  logic           add_cin;
  logic [7:0]     add_sum;
  logic           add_cout;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [7:0]     rsp_sum;
  logic           rsp_cout;
  logic           rsp_chained;

  modport slave (
    input  req, lock, a_in, b_in, cin_in, add_sum, add_cout,
    output gnt, add_a, add_b, add_cin,
           rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_chained
  );

  modport master (
    output req, lock, a_in, b_in, cin_in, add_sum, add_cout,
    input  gnt, add_a, add_b, add_cin,
           rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_chained
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one registered 8-bit adder between N requesters. One requester
//   is granted per cycle in round-robin order and its operands are steered
//   to the adder; the result comes back one cycle later tagged with the
//   requester id. A requester that asserts lock keeps the adder for its
//   next operation, and that operation takes its carry-in from the
//   previous result's cout (multi-byte additions).
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  adder_arbiter_if.slave (requests, adder link, responses)
module adder_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input logic           clk,
  input logic           rst,
  adder_arbiter_if.slave bus
);

  logic [IDW-1:0] rr_ptr;
  logic           owner_vld;
  logic [IDW-1:0] owner_id;
  logic           iss_vld;
  logic [IDW-1:0] iss_id;
  logic           iss_chain;

  logic           issue;
  logic           cont;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] next_ptr;
  int             srch_idx;

  // Grant selection. A lock holder that still requests wins outright (a
  // locked continuation). If it dropped req the lock is simply ignored
  // here, so plain round-robin serves another requester in the same cycle.
  always_comb begin
    issue    = 1'b0;
    cont     = 1'b0;
    gnt_idx  = '0;
    srch_idx = 0;
    if (!rst) begin
      if (owner_vld && bus.req[owner_id]) begin
        issue   = 1'b1;
        cont    = 1'b1;
        gnt_idx = owner_id;
      end else begin
        for (int k = 0; k < N; k++) begin
          srch_idx = int'(rr_ptr) + k;
          if (srch_idx >= N) srch_idx = srch_idx - N;
          if (!issue && bus.req[srch_idx]) begin
            issue   = 1'b1;
            gnt_idx = IDW'(srch_idx);
          end
        end
      end
    end
  end

  // Explicit wrap keeps rr_ptr inside 0..N-1 when N is not a power of two.
  assign next_ptr = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;

  assign bus.gnt   = issue ? (N'(1) << gnt_idx) : '0;
  assign bus.add_a = issue ? bus.a_in[int'(gnt_idx)*8 +: 8] : 8'h00;
  assign bus.add_b = issue ? bus.b_in[int'(gnt_idx)*8 +: 8] : 8'h00;
  // add_cout currently holds the result of the owner's previous locked
  // operation, which is exactly the carry the continuation needs.
  assign bus.add_cin = cont ? bus.add_cout : (issue & bus.cin_in[gnt_idx]);

  // Arbitration, lock and issue-stage state. Without an issue the lock
  // is dropped: the owner no longer requests, so it has let go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      owner_vld <= 1'b0;
      owner_id  <= '0;
      iss_vld   <= 1'b0;
      iss_id    <= '0;
      iss_chain <= 1'b0;
    end else if (issue) begin
      rr_ptr    <= next_ptr;
      owner_vld <= bus.lock[gnt_idx];
      owner_id  <= gnt_idx;
      iss_vld   <= 1'b1;
      iss_id    <= gnt_idx;
      iss_chain <= cont;
    end else begin
      owner_vld <= 1'b0;
      iss_vld   <= 1'b0;
      iss_chain <= 1'b0;
    end
  end

  assign bus.rsp_valid   = iss_vld;
  assign bus.rsp_id      = iss_id;
  assign bus.rsp_chained = iss_chain;
  assign bus.rsp_sum     = bus.add_sum;
  assign bus.rsp_cout    = bus.add_cout;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
//   Bench for adder_arbiter with N=4. Provides the external registered
//   adder, a table of directed vectors with hand-computed results, a few
//   hand-written sequences (async reset mid-chain) and a randomized run,
//   all also checked against a behavioural reference model.
module tb_adder_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  adder_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // External adder: sum and carry registered one cycle after operands.
  always_ff @(posedge clk)
    {bus.add_cout, bus.add_sum} <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + 9'(bus.add_cin);

  int checks = 0;
  int errors = 0;

  // Reference model: pointer, lock owner (-1 = none), last issued carry,
  // and the response expected in the following cycle.
  int m_ptr, m_owner, m_prev_cout;
  bit e_vld;
  int e_id, e_sum, e_cout, e_chain;

  typedef struct {
    bit          rst_before;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cin;
    logic [3:0]  gnt;
    int          id;
    int          sum;
    int          cout;
    int          chain;
  } vec_t;

  vec_t tbl[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_ptr       = 0;
    m_owner     = -1;
    m_prev_cout = 0;
    e_vld       = 1'b0;
  endtask

  task automatic doReset();
    rst        = 1'b1;
    bus.req    = '0;
    bus.lock   = '0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.cin_in = '0;
    @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("reset_rsp_chained", 32'(bus.rsp_chained), 32'd0);
    checkOutput("reset_gnt", 32'(bus.gnt), 32'd0);
    rst = 1'b0;
    modelReset();
  endtask

  // Drive one cycle of inputs right after a rising edge, check the
  // combinational outputs and the pending response at the falling edge,
  // then advance the model across the next rising edge.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] cin, output logic [3:0] seen_gnt);
    int g;
    bit cont;
    int av, bv, cv, res;
    logic [3:0] exp_gnt;
    bus.req    = req;
    bus.lock   = lock;
    bus.a_in   = a;
    bus.b_in   = b;
    bus.cin_in = cin;
    g    = -1;
    cont = 1'b0;
    av   = 0;
    bv   = 0;
    cv   = 0;
    res  = 0;
    if (m_owner >= 0 && req[m_owner]) begin
      g    = m_owner;
      cont = 1'b1;
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    if (g >= 0) begin
      av  = int'(a[8*g +: 8]);
      bv  = int'(b[8*g +: 8]);
      cv  = cont ? m_prev_cout : int'(cin[g]);
      res = av + bv + cv;
      exp_gnt = 4'(1) << g;
    end else begin
      exp_gnt = 4'd0;
    end
    @(negedge clk);
    seen_gnt = bus.gnt;
    checkOutput("model_rsp_valid", 32'(bus.rsp_valid), 32'(e_vld));
    if (e_vld) begin
      checkOutput("model_rsp_id", 32'(bus.rsp_id), 32'(e_id));
      checkOutput("model_rsp_sum", 32'(bus.rsp_sum), 32'(e_sum));
      checkOutput("model_rsp_cout", 32'(bus.rsp_cout), 32'(e_cout));
      checkOutput("model_rsp_chained", 32'(bus.rsp_chained), 32'(e_chain));
    end
    checkOutput("model_gnt", 32'(bus.gnt), 32'(exp_gnt));
    checkOutput("model_add_a", 32'(bus.add_a), 32'(av));
    checkOutput("model_add_b", 32'(bus.add_b), 32'(bv));
    checkOutput("model_add_cin", 32'(bus.add_cin), 32'(cv));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      e_vld       = 1'b1;
      e_id        = g;
      e_sum       = res & 255;
      e_cout      = res >> 8;
      e_chain     = int'(cont);
      m_ptr       = (g + 1) % N;
      m_owner     = lock[g] ? g : -1;
      m_prev_cout = e_cout;
    end else begin
      e_vld   = 1'b0;
      m_owner = -1;
    end
  endtask

  initial begin
    logic [3:0] seen;

    // Single request after reset
    tbl.push_back('{1, 4'b0001, 4'b0000, 32'h000000F0, 32'h00000020, 4'b0001, 4'b0001, 0, 'h11, 1, 0});
    // Round-robin fairness from reset
    for (int r = 0; r < 8; r++)
      tbl.push_back('{(r == 0), 4'b1111, 4'b0000, 32'h40302010, 32'h04030201, 4'b0000,
                      4'(1) << (r % 4), r % 4, 'h11 * ((r % 4) + 1), 0, 0});
    // 16-bit chain 16'h12FF + 16'h0001 by requester 2 while all request
    tbl.push_back('{1, 4'b0100, 4'b0100, 32'h00FF0000, 32'h00010000, 4'b0000, 4'b0100, 2, 'h00, 1, 0});
    tbl.push_back('{0, 4'b1111, 4'b0000, 32'h00120000, 32'h00000000, 4'b0000, 4'b0100, 2, 'h13, 0, 1});
    tbl.push_back('{0, 4'b1111, 4'b0000, 32'h00120000, 32'h00000000, 4'b0000, 4'b1000, 3, 'h00, 0, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 0, 0, 0, 0});
    // Lock release when owner 1 drops req
    tbl.push_back('{1, 4'b0010, 4'b0010, 32'h00000500, 32'h00000600, 4'b0000, 4'b0010, 1, 'h0B, 0, 0});
    tbl.push_back('{0, 4'b1100, 4'b0000, 32'h00100000, 32'h00200000, 4'b0100, 4'b0100, 2, 'h31, 0, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 0, 0, 0, 0});
    // Idle gaps
    for (int r = 0; r < 6; r++)
      tbl.push_back('{(r == 0), (r % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000, 32'h00070000,
                      32'h00080000, 4'b0000, (r % 2 == 0) ? 4'b0100 : 4'b0000, 2, 'h0F, 0, 0});

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) doReset();
      applyStimulus(tbl[i].req, tbl[i].lock, tbl[i].a, tbl[i].b, tbl[i].cin, seen);
      checkOutput($sformatf("tbl%0d_gnt", i), 32'(seen), 32'(tbl[i].gnt));
      if (tbl[i].gnt != 4'd0) begin
        checkOutput($sformatf("tbl%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
        checkOutput($sformatf("tbl%0d_rsp_id", i), 32'(bus.rsp_id), 32'(tbl[i].id));
        checkOutput($sformatf("tbl%0d_rsp_sum", i), 32'(bus.rsp_sum), 32'(tbl[i].sum));
        checkOutput($sformatf("tbl%0d_rsp_cout", i), 32'(bus.rsp_cout), 32'(tbl[i].cout));
        checkOutput($sformatf("tbl%0d_rsp_chained", i), 32'(bus.rsp_chained), 32'(tbl[i].chain));
      end else begin
        checkOutput($sformatf("tbl%0d_rsp_idle", i), 32'(bus.rsp_valid), 32'd0);
      end
    end

    // Reset mid-chain: owner 0 locked, result (cout=1) in flight, short
    // async reset pulse that leaves the adder's cout at 1.
    doReset();
    applyStimulus(4'b0001, 4'b0001, 32'h000000FF, 32'h00000001, 4'b0000, seen);
    checkOutput("midrst_inflight_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("midrst_inflight_cout", 32'(bus.rsp_cout), 32'd1);
    rst     = 1'b1;
    bus.req = 4'b0011;
    #1;
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midrst_gnt", 32'(bus.gnt), 32'd0);
    rst = 1'b0;
    modelReset();
    applyStimulus(4'b0011, 4'b0000, 32'h00000101, 32'h00000101, 4'b0000, seen);
    checkOutput("midrst_next_gnt", 32'(seen), 32'h1);
    checkOutput("midrst_next_sum", 32'(bus.rsp_sum), 32'h02);
    checkOutput("midrst_next_chained", 32'(bus.rsp_chained), 32'd0);

    // Randomized traffic against the model
    doReset();
    for (int r = 0; r < 400; r++)
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom & $urandom),
                    $urandom, $urandom, 4'($urandom_range(0, 15)), seen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one registered 8-bit add unit (sum/carry out one cycle after operands are presented) between N requesters. It picks one requester per cycle and steers that requester's operands to the adder. Each result is returned one cycle later, tagged with the requester ID. A lock mechanism lets one requester hold the adder for back-to-back multi-byte additions, with carry chained automatically from the adder's cout.

## Interface
- N, default 4: number of requesters (2..8).
- IDW, default 2: ID width, equal to clog2(N).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N  per-requester operation request.
- lock  in  N  per-requester: keep the grant after this operation and chain the carry.
- a_in  in  8*N  operand A; requester i uses bits [8i+7:8i].
- b_in  in  8*N  operand B; same packing as a_in.
- cin_in  in  N  per-requester carry-in; ignored when chained.
- gnt  out  N  one-hot accept, combinational; an operation is issued when req[i] and gnt[i] are both high.
- add_a  out  8  adder operand A, combinational from the granted requester.
- add_b  out  8  adder operand B.
- add_cin  out  1  adder carry-in.
- add_sum  in  8  adder sum, registered inside the adder.
- add_cout  in  1  adder carry-out, registered inside the adder.
- rsp_valid  out  1  result valid (registered).
- rsp_id  out  IDW  requester that owns the result (registered).
- rsp_sum  out  8  equal to add_sum; meaningful only while rsp_valid is high.
- rsp_cout  out  1  equal to add_cout.
- rsp_chained  out  1  high when this result's carry-in came from the previous result's cout (registered).

## Operation
- State registers:
  - rr_ptr[IDW-1:0]: highest-priority index.
  - owner_vld, owner_id: lock state.
  - iss_vld, iss_id, iss_chain: issue pipeline stage feeding rsp_*.
- Arbitration when owner_vld=0: grant the first index with req set, searching rr_ptr, rr_ptr+1, … modulo N.
- Arbitration when owner_vld=1 and req[owner_id]=1: grant owner_id only. All other requesters are blocked.
- If owner_vld=1 but req[owner_id]=0: the lock is released in that same cycle and normal round-robin applies in that cycle.
- At most one bit of gnt is high. gnt=0 when req=0.
- On issue to index g:
  - rr_ptr <= (g+1) mod N, also when the grant comes from the lock.
  - owner_vld <= lock[g]; owner_id <= g.
  - iss_vld <= 1; iss_id <= g.
  - iss_chain <= 1 if the grant was a locked continuation, else 0.
- Carry source: add_cin = add_cout when the grant is a locked continuation, otherwise cin_in[g]. This is valid because the previous locked operation's result is on add_cout in exactly this cycle.
- No issue in a cycle: iss_vld <= 0. add_a, add_b and add_cin are driven to 0 (add_cin 0 only if not chained).
- rsp_valid, rsp_id and rsp_chained are iss_vld, iss_id and iss_chain.
- Chain example: a 16-bit add is two locked issues. Requester asserts lock on the low byte and deasserts lock on the high byte. It receives two responses, with rsp_chained=0 then 1.

## Timing
- Latency: issue in cycle T gives rsp_valid in T+1. Throughput is one operation per cycle. There is no backpressure on responses.
- Reset values: rsp_valid=0, rsp_id=0, rsp_chained=0, rr_ptr=0, owner_vld=0.
- gnt is combinational from req, lock state and rr_ptr. It reads 0 while rst is high.
- Reset mid-chain: the lock is discarded and any in-flight result is dropped (rsp_valid=0 immediately). After reset the first grant uses cin_in.
- lock[g] is sampled only in the issue cycle. lock on non-granted requesters is ignored.
- N not a power of two: rr_ptr wraps from N-1 to 0 and never holds a value ≥ N.
- Simultaneous case: the owner drops req while another requester raises req. The other requester may be granted in that same cycle with its own cin_in and rsp_chained=0.

## Test plan
- Single request, after reset: req=0001, a=8'hF0, b=8'h20, cin=1. Required: gnt=0001 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=8'h11, rsp_cout=1, rsp_chained=0.
- Round-robin fairness: req=1111 held for 8 cycles, no lock. Required: grant order 0,1,2,3,0,1,2,3, and every response id matches that order.
- 16-bit chain: requester 2 adds 16'h12FF + 16'h0001. It issues the low byte with lock=1, then the high byte with lock=0, cin_in[2]=0, while req=1111. Required: second grant is 2; responses sum=8'h00/cout=1/chained=0, then sum=8'h13/cout=0/chained=1; requester 3 is granted next.
- Lock release on req drop: owner 1 locked, then req=1100. Required: grant goes to 2 in that cycle, add_cin = cin_in[2], rsp_chained=0.
- Reset mid-chain: assert rst for one cycle while owner 0 is locked and a result is in flight. Required: rsp_valid=0 during rst; the next req=0011 is granted to 0 (rr_ptr=0), and its cin comes from cin_in.
- Idle gaps: alternate req=0100 with req=0000. Required: rsp_valid pulses one cycle after each issue, with no spurious responses.
